uart_tx_serializer: RTL and testbench

Transmit serializer for the UART peripheral. It pops bytes from the TX FIFO through a valid/ready handshake and drives the serial `tx_o` line with start, data, optional parity and stop bits. Bit timing comes from the clock divisor register; frame format comes from the configuration register. It sits directly downstream of the TX FIFO that the register interface pushes into.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_baud_cnt.sv | 33 +++
 rtl/uart_tx_serializer.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter with latched divisor and divisor-of-0 clamp
module uart_baud_cnt #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  load,
    input  logic                  active,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  bit_done
);

    logic [DATA_WIDTH-1:0] div_q;
    logic [DATA_WIDTH-1:0] cnt_q;

    assign bit_done = active && (cnt_q == (div_q - DATA_WIDTH'(1)));

    // The divisor is captured only on load so register writes mid-frame cannot stretch a bit.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            div_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            div_q <= (divisor == '0) ? DATA_WIDTH'(1) : divisor;
            cnt_q <= '0;
        end else if (bit_done) begin
            cnt_q <= '0;
        end else if (active) begin
            cnt_q <= cnt_q + DATA_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART TX frame serializer; parity support under UART_TX_PARITY_EN
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  clk_en_i,
    input  logic [DATA_WIDTH-1:0] clk_div_i,
    input  logic                  cfg_parity_en_i,
    input  logic                  cfg_parity_type_i,
    input  logic                  cfg_stop_bits_i,
    input  logic [7:0]            data_i,
    input  logic                  data_valid_i,
    output logic                  data_ready_o,
    output logic                  tx_o,
    output logic                  busy_o
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_tx_state_e state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic           stop2_q, stop2_d;
    logic           stop_idx_q, stop_idx_d;
    logic           tx_q, tx_d;
    logic           bit_done;
    logic           last_stop;
    logic           accept;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic parity_q, parity_d;
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = cfg_parity_en_i ^ cfg_parity_type_i;
`endif

    assign last_stop    = (state_q == STOP) && bit_done && (!stop2_q || stop_idx_q);
    assign data_ready_o = clk_en_i && ((state_q == IDLE) || last_stop);
    assign accept       = data_ready_o && data_valid_i;
    assign tx_o         = tx_q;
    assign busy_o       = (state_q != IDLE);

    uart_baud_cnt #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_baud_cnt (
        .clk_i    (clk_i),
        .arst_ni  (arst_ni),
        .load     (accept),
        .active   (state_q != IDLE),
        .divisor  (clk_div_i),
        .bit_done (bit_done)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
`ifdef UART_TX_PARITY_EN
        par_en_d   = par_en_q;
        parity_d   = parity_q;
`endif
        case (state_q)
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d  = '0;
                        stop_idx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                        state_d    = par_en_q ? PARITY : STOP;
`else
                        state_d    = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                end
            end
`endif
            STOP: begin
                if (last_stop) begin
                    state_d = IDLE;
                end else if (bit_done) begin
                    stop_idx_d = 1'b1;
                end
            end
            default: ;
        endcase

        // An accept on the final stop cycle overrides the return to IDLE.
        if (accept) begin
            state_d    = START;
            shift_d    = data_i;
            bit_idx_d  = '0;
            stop2_d    = cfg_stop_bits_i;
            stop_idx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_d   = cfg_parity_en_i;
            parity_d   = (^data_i) ^ cfg_parity_type_i;
`endif
        end

        // tx is registered, so it is decoded from the next state.
        tx_d = 1'b1;
        case (state_d)
            START:  tx_d = 1'b0;
            DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            par_en_q <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            par_en_q <= par_en_d;
            parity_q <= parity_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - randomized self-checking bench against a frame-level line model
module tb_uart_tx_serializer;

    logic        clk_i = 1'b0;
    logic        arst_ni;
    logic        clk_en_i;
    logic [31:0] clk_div_i;
    logic        cfg_parity_en_i;
    logic        cfg_parity_type_i;
    logic        cfg_stop_bits_i;
    logic [7:0]  data_i;
    logic        data_valid_i;
    logic        data_ready_o;
    logic        tx_o;
    logic        busy_o;

    int vec_cnt = 0;
    int err_cnt = 0;
    bit exp_q[$];

    uart_tx_serializer #(.DATA_WIDTH(32)) dut (
        .clk_i             (clk_i),
        .arst_ni           (arst_ni),
        .clk_en_i          (clk_en_i),
        .clk_div_i         (clk_div_i),
        .cfg_parity_en_i   (cfg_parity_en_i),
        .cfg_parity_type_i (cfg_parity_type_i),
        .cfg_stop_bits_i   (cfg_stop_bits_i),
        .data_i            (data_i),
        .data_valid_i      (data_valid_i),
        .data_ready_o      (data_ready_o),
        .tx_o              (tx_o),
        .busy_o            (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line model: list of frame bits, each repeated for the effective divisor.
    task automatic build_expect(input logic [7:0] b, input int div, input bit pe, input bit pt, input bit s2);
        int d;
        bit bits[$];
        d = (div == 0) ? 1 : div;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        if (pe) bits.push_back(pt ? ~^b : ^b);
`else
        begin
            int unused_par;
            unused_par = int'(pe) + int'(pt);
        end
`endif
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[j]) for (int r = 0; r < d; r++) exp_q.push_back(bits[j]);
    endtask

    // mode 0: plain frame, 1: registers changed mid-frame, 2: clk_en dropped mid-frame with valid held
    task automatic send(input logic [7:0] b, input int div, input bit pe, input bit pt, input bit s2,
                        input int mode);
        int  len, busy_n, rdy_n;
        bit  txbad;
        exp_q.delete();
        build_expect(b, div, pe, pt, s2);
        len = exp_q.size();
        @(negedge clk_i);
        clk_div_i = div; cfg_parity_en_i = pe; cfg_parity_type_i = pt; cfg_stop_bits_i = s2;
        data_i = b; data_valid_i = 1'b1; clk_en_i = 1'b1;
        #1 check_eq("ready_idle", data_ready_o, 1);
        @(posedge clk_i);
        busy_n = 0; rdy_n = 0; txbad = 0;
        for (int k = 0; k < len; k++) begin
            @(negedge clk_i);
            if (!txbad) begin
                check_eq($sformatf("tx_bit[%0d] byte %02h D%0d", k, b, div), tx_o, exp_q[k]);
                txbad = (tx_o !== exp_q[k]);
            end
            busy_n += int'(busy_o);
            rdy_n  += int'(data_ready_o);
            if (mode != 2) data_valid_i = 1'b0;
            if (k == 3 && mode == 1) begin clk_div_i = 8; cfg_stop_bits_i = !s2; end
            if (k == 3 && mode == 2) clk_en_i = 1'b0;
        end
        check_eq("busy_cycles", busy_n, len);
        check_eq("ready_pulses", rdy_n, (mode == 2) ? 0 : 1);
        @(negedge clk_i);
        check_eq("busy_after", busy_o, 0);
        check_eq("tx_after", tx_o, 1);
        check_eq("ready_after", data_ready_o, (mode == 2) ? 0 : 1);
        if (mode == 2) begin
            busy_n = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk_i);
                busy_n += int'(busy_o || !tx_o || data_ready_o);
            end
            check_eq("no_pop_clk_en_low", busy_n, 0);
            data_valid_i = 1'b0;
            clk_en_i = 1'b1;
        end
    endtask

    initial begin
        int n, txbad, l1;
        arst_ni = 1'b0; clk_en_i = 1'b0; clk_div_i = 4; cfg_parity_en_i = 0;
        cfg_parity_type_i = 0; cfg_stop_bits_i = 0; data_i = 8'h00; data_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check_eq("rst_tx", tx_o, 1);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_ready", data_ready_o, 0);
        arst_ni = 1'b1;

        // clk_en low with valid high: nothing popped, line idle
        data_i = 8'h3C; data_valid_i = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            n += int'(data_ready_o || busy_o || !tx_o);
        end
        check_eq("clk_en_low_idle", n, 0);
        data_valid_i = 1'b0;

        send(8'hA5, 4, 0, 0, 0, 0);
        send(8'hA5, 4, 1, 0, 0, 0);
        send(8'hA5, 4, 1, 1, 0, 0);
        send(8'hA5, 4, 1, 1, 1, 0);
        send(8'hFF, 0, 0, 0, 0, 0);
        send(8'h96, 4, 0, 0, 0, 1);
        send(8'h69, 8, 0, 0, 1, 0);
        send(8'hC3, 3, 1, 0, 0, 2);

        // Back-to-back: 0x01 then 0x80 with valid held, D = 3
        exp_q.delete();
        build_expect(8'h01, 3, 0, 0, 0);
        l1 = exp_q.size();
        build_expect(8'h80, 3, 0, 0, 0);
        @(negedge clk_i);
        clk_div_i = 3; cfg_parity_en_i = 0; cfg_stop_bits_i = 0; clk_en_i = 1'b1;
        data_i = 8'h01; data_valid_i = 1'b1;
        @(posedge clk_i);
        n = 0; txbad = 0;
        begin
            int busy_n;
            busy_n = 0;
            for (int k = 0; k < exp_q.size(); k++) begin
                @(negedge clk_i);
                if (txbad == 0) begin
                    check_eq($sformatf("b2b_tx[%0d]", k), tx_o, exp_q[k]);
                    txbad = int'(tx_o !== exp_q[k]);
                end
                busy_n += int'(busy_o);
                n += int'(data_ready_o && data_valid_i);
                if (k == 0) data_i = 8'h80;
                if (k == l1 - 1) begin
                    check_eq("b2b_ready_last_stop", data_ready_o, 1);
                end
                if (k >= l1) data_valid_i = 1'b0;
            end
            check_eq("b2b_busy_cycles", busy_n, exp_q.size());
        end
        check_eq("b2b_pops_in_frame", n, 1);
        @(negedge clk_i);
        check_eq("b2b_idle_after", busy_o, 0);

        // Async reset during DATA bit 3
        exp_q.delete();
        build_expect(8'h5A, 4, 0, 0, 0);
        @(negedge clk_i);
        clk_div_i = 4; data_i = 8'h5A; data_valid_i = 1'b1;
        @(posedge clk_i);
        txbad = 0;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk_i);
            data_valid_i = 1'b0;
            if (txbad == 0) begin
                check_eq($sformatf("pre_rst_tx[%0d]", k), tx_o, exp_q[k]);
                txbad = int'(tx_o !== exp_q[k]);
            end
        end
        arst_ni = 1'b0;
        #1;
        check_eq("rst_mid_tx", tx_o, 1);
        check_eq("rst_mid_busy", busy_o, 0);
        @(negedge clk_i);
        arst_ni = 1'b1;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_i);
            n += int'(busy_o || !tx_o);
        end
        check_eq("rst_no_resend", n, 0);

        // Randomized frames
        for (int t = 0; t < 30; t++) begin
            send(8'($urandom), int'($urandom_range(0, 6)), 1'($urandom), 1'($urandom), 1'($urandom), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
